// File: rtl/symcounter_pkg.sv
// Shared types and 7-segment helpers for the round sequencer.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}. The DP bit is held off.
package symcounter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHOW  = 3'd1,
        ASK   = 3'd2,
        WAIT  = 3'd3,
        JUDGE = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } round_state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hD8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Any value outside 0..9 renders as a blank digit.
    function automatic logic [7:0] int_to_seg(input int v);
        logic [7:0] seg;
        case (v)
            0:       seg = SEG_0;
            1:       seg = SEG_1;
            2:       seg = SEG_2;
            3:       seg = SEG_3;
            4:       seg = SEG_4;
            5:       seg = SEG_5;
            6:       seg = SEG_6;
            7:       seg = SEG_7;
            8:       seg = SEG_8;
            9:       seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer and its environment.
// The scoreSeg0/1 displays exist only when ROUND_SEQ_SEG_EN is defined.
interface round_sequencer_if;

    logic       tick1Hz;
    logic       startBtn;
    logic [7:0] symbolCount;
    logic [7:0] userCount;
    logic       postSig;
    logic       answerSig;
    logic       genEnable;
    logic       clearCount;
    logic       busy;
    logic [3:0] roundNum;
    logic [7:0] score;
    logic       resultValid;
    logic       correct;
`ifdef ROUND_SEQ_SEG_EN
    logic [7:0] scoreSeg0;
    logic [7:0] scoreSeg1;
`endif

    modport master (
`ifdef ROUND_SEQ_SEG_EN
        input  scoreSeg0, scoreSeg1,
`endif
        output tick1Hz, startBtn, symbolCount, userCount, postSig,
        input  answerSig, genEnable, clearCount, busy, roundNum, score,
               resultValid, correct
    );

    modport slave (
`ifdef ROUND_SEQ_SEG_EN
        output scoreSeg0, scoreSeg1,
`endif
        input  tick1Hz, startBtn, symbolCount, userCount, postSig,
        output answerSig, genEnable, clearCount, busy, roundNum, score,
               resultValid, correct
    );

endinterface

// File: rtl/seg_digit_enc.sv
// Registered encoder from a single digit to an active-low 7-segment code.
// Codes 10..15 show a blank digit. The sequencer drives 4'hF to blank a digit.
module seg_digit_enc
    import symcounter_pkg::*;
(
    input  logic       Clk100M,
    input  logic       RstN,
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            seg <= SEG_BLANK;
        end else begin
            seg <= int_to_seg(int'(digit));
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// Game-round sequencer: show symbols, open the answer period, judge, repeat.
// Define ROUND_SEQ_SEG_EN to add the registered 7-segment score outputs.
module round_sequencer
    import symcounter_pkg::*;
#(
    parameter int SHOW_SECONDS = 10,
    parameter int ROUNDS       = 5,
    parameter int WAIT_TIMEOUT = 8
) (
    input  logic              Clk100M,
    input  logic              RstN,
    round_sequencer_if.slave  bus
);

    localparam logic [5:0] SHOW_LAST = 6'(SHOW_SECONDS - 1);
    localparam logic [5:0] WAIT_LAST = 6'(WAIT_TIMEOUT - 1);
    localparam logic [3:0] LAST_RND  = 4'(ROUNDS);

    round_state_t state;
    logic [5:0]   tickCnt;
    logic         answerQ;
    logic         genQ;
    logic         clearQ;
    logic         busyQ;
    logic [3:0]   roundQ;
    logic [7:0]   scoreQ;
    logic         validQ;
    logic         correctQ;
    logic         countsEq;

    function automatic logic [7:0] score_add(input logic [7:0] s, input logic inc);
        if (inc && (s != 8'hFF)) begin
            return s + 8'd1;
        end
        return s;
    endfunction

    assign countsEq = (bus.userCount == bus.symbolCount);

    always_ff @(posedge Clk100M or negedge RstN) begin
        if (!RstN) begin
            state    <= IDLE;
            tickCnt  <= '0;
            answerQ  <= 1'b0;
            genQ     <= 1'b0;
            clearQ   <= 1'b0;
            busyQ    <= 1'b0;
            roundQ   <= '0;
            scoreQ   <= '0;
            validQ   <= 1'b0;
            correctQ <= 1'b0;
        end else begin
            answerQ <= 1'b0;
            clearQ  <= 1'b0;
            validQ  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.startBtn) begin
                        state   <= SHOW;
                        scoreQ  <= '0;
                        roundQ  <= 4'd1;
                        clearQ  <= 1'b1;
                        genQ    <= 1'b1;
                        busyQ   <= 1'b1;
                        tickCnt <= '0;
                    end
                end
                SHOW: begin
                    if (bus.tick1Hz) begin
                        if (tickCnt == SHOW_LAST) begin
                            tickCnt <= '0;
                            state   <= ASK;
                            answerQ <= 1'b1;
                            genQ    <= 1'b0;
                        end else begin
                            tickCnt <= tickCnt + 6'd1;
                        end
                    end
                end
                ASK: begin
                    tickCnt <= '0;
                    state   <= WAIT;
                end
                // The verdict is registered on the leaving edge so that it is
                // visible in the cycle after postSig. JUDGE then only spaces
                // out the round.
                WAIT: begin
                    if (bus.postSig) begin
                        correctQ <= countsEq;
                        scoreQ   <= score_add(scoreQ, countsEq);
                        validQ   <= 1'b1;
                        tickCnt  <= '0;
                        state    <= JUDGE;
                    end else if (bus.tick1Hz) begin
                        if (tickCnt == WAIT_LAST) begin
                            correctQ <= 1'b0;
                            validQ   <= 1'b1;
                            tickCnt  <= '0;
                            state    <= JUDGE;
                        end else begin
                            tickCnt <= tickCnt + 6'd1;
                        end
                    end
                end
                JUDGE: begin
                    state <= NEXT;
                end
                NEXT: begin
                    if (roundQ < LAST_RND) begin
                        roundQ <= roundQ + 4'd1;
                        clearQ <= 1'b1;
                        genQ   <= 1'b1;
                        state  <= SHOW;
                    end else begin
                        busyQ <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.answerSig   = answerQ;
    assign bus.genEnable   = genQ;
    assign bus.clearCount  = clearQ;
    assign bus.busy        = busyQ;
    assign bus.roundNum    = roundQ;
    assign bus.score       = scoreQ;
    assign bus.resultValid = validQ;
    assign bus.correct     = correctQ;

`ifdef ROUND_SEQ_SEG_EN
    logic [7:0] tens;
    logic [7:0] ones;
    logic [3:0] tensDigit;
    logic [3:0] onesDigit;

    // Tens above 9 (score 100..255) cannot be shown on one digit, so that digit is blanked.
    always_comb begin
        tens      = scoreQ / 8'd10;
        ones      = scoreQ % 8'd10;
        tensDigit = 4'hF;
        onesDigit = 4'hF;
        if (state != IDLE) begin
            tensDigit = (tens > 8'd9) ? 4'hF : tens[3:0];
            onesDigit = ones[3:0];
        end
    end

    seg_digit_enc u_seg0 (
        .Clk100M (Clk100M),
        .RstN    (RstN),
        .digit   (tensDigit),
        .seg     (bus.scoreSeg0)
    );

    seg_digit_enc u_seg1 (
        .Clk100M (Clk100M),
        .RstN    (RstN),
        .digit   (onesDigit),
        .seg     (bus.scoreSeg1)
    );
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer (ROUNDS=2, SHOW_SECONDS=3, WAIT_TIMEOUT=2).
// The segment checks compile in only when ROUND_SEQ_SEG_EN is defined.
module tb_round_sequencer;

    logic Clk100M;
    logic RstN;
    int   nTests;
    int   nFail;

    round_sequencer_if bus();

    round_sequencer #(
        .SHOW_SECONDS (3),
        .ROUNDS       (2),
        .WAIT_TIMEOUT (2)
    ) dut (
        .Clk100M (Clk100M),
        .RstN    (RstN),
        .bus     (bus)
    );

    initial Clk100M = 1'b0;
    always #5 Clk100M = ~Clk100M;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk100M);
    endtask

    task automatic tick();
        bus.tick1Hz = 1'b1;
        cyc();
        bus.tick1Hz = 1'b0;
    endtask

    task automatic start();
        bus.startBtn = 1'b1;
        cyc();
        bus.startBtn = 1'b0;
    endtask

    task automatic post(input logic [7:0] u, input logic [7:0] s);
        bus.userCount   = u;
        bus.symbolCount = s;
        bus.postSig     = 1'b1;
        cyc();
        bus.postSig     = 1'b0;
    endtask

    task automatic show_to_wait(input string tag);
        tick();
        cyc();
        tick();
        tick();
        chk({tag, "_answer"}, {7'd0, bus.answerSig}, 8'd1);
        chk({tag, "_gen_off"}, {7'd0, bus.genEnable}, 8'd0);
        cyc();
        chk({tag, "_answer_1cyc"}, {7'd0, bus.answerSig}, 8'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_answer"}, {7'd0, bus.answerSig}, 8'd0);
        chk({tag, "_gen"},    {7'd0, bus.genEnable}, 8'd0);
        chk({tag, "_clear"},  {7'd0, bus.clearCount}, 8'd0);
        chk({tag, "_busy"},   {7'd0, bus.busy}, 8'd0);
        chk({tag, "_round"},  {4'd0, bus.roundNum}, 8'd0);
        chk({tag, "_score"},  bus.score, 8'd0);
        chk({tag, "_valid"},  {7'd0, bus.resultValid}, 8'd0);
        chk({tag, "_correct"}, {7'd0, bus.correct}, 8'd0);
    endtask

    initial begin
        nTests          = 0;
        nFail           = 0;
        RstN            = 1'b0;
        bus.tick1Hz     = 1'b0;
        bus.startBtn    = 1'b0;
        bus.postSig     = 1'b0;
        bus.symbolCount = 8'd0;
        bus.userCount   = 8'd0;
        repeat (2) cyc();
        chk_zero("reset");
`ifdef ROUND_SEQ_SEG_EN
        chk("reset_seg0", bus.scoreSeg0, 8'hFF);
        chk("reset_seg1", bus.scoreSeg1, 8'hFF);
`endif
        RstN = 1'b1;
        cyc();

        // Normal game: round 1 correct, round 2 wrong.
        start();
        chk("start_gen",   {7'd0, bus.genEnable}, 8'd1);
        chk("start_clear", {7'd0, bus.clearCount}, 8'd1);
        chk("start_busy",  {7'd0, bus.busy}, 8'd1);
        chk("start_round", {4'd0, bus.roundNum}, 8'd1);
        cyc();
        chk("clear_1cyc",  {7'd0, bus.clearCount}, 8'd0);
        post(8'd7, 8'd7);
        chk("post_in_show_valid", {7'd0, bus.resultValid}, 8'd0);
        chk("post_in_show_gen",   {7'd0, bus.genEnable}, 8'd1);
        show_to_wait("r1");
        start();
        chk("start_in_wait_round", {4'd0, bus.roundNum}, 8'd1);
        chk("start_in_wait_clear", {7'd0, bus.clearCount}, 8'd0);
        post(8'd7, 8'd7);
        chk("r1_valid",   {7'd0, bus.resultValid}, 8'd1);
        chk("r1_correct", {7'd0, bus.correct}, 8'd1);
        chk("r1_score",   bus.score, 8'd1);
        cyc();
        chk("r1_valid_1cyc", {7'd0, bus.resultValid}, 8'd0);
        chk("r1_next_gen",   {7'd0, bus.genEnable}, 8'd0);
        cyc();
        chk("r2_gen",   {7'd0, bus.genEnable}, 8'd1);
        chk("r2_clear", {7'd0, bus.clearCount}, 8'd1);
        chk("r2_round", {4'd0, bus.roundNum}, 8'd2);
        show_to_wait("r2");
        post(8'd5, 8'd6);
        chk("r2_valid",   {7'd0, bus.resultValid}, 8'd1);
        chk("r2_correct", {7'd0, bus.correct}, 8'd0);
        chk("r2_score",   bus.score, 8'd1);
        cyc();
        cyc();
        chk("done_busy",  {7'd0, bus.busy}, 8'd0);
        chk("done_round", {4'd0, bus.roundNum}, 8'd2);
        chk("done_score", bus.score, 8'd1);
        chk("done_clear", {7'd0, bus.clearCount}, 8'd0);

        // Timeout game: round 1 times out, round 2 postSig collides with the timeout tick.
        start();
        chk("g2_score", bus.score, 8'd0);
        chk("g2_round", {4'd0, bus.roundNum}, 8'd1);
        show_to_wait("g2r1");
        tick();
        chk("to_tick1_valid", {7'd0, bus.resultValid}, 8'd0);
        tick();
        chk("to_valid",   {7'd0, bus.resultValid}, 8'd1);
        chk("to_correct", {7'd0, bus.correct}, 8'd0);
        chk("to_score",   bus.score, 8'd0);
        cyc();
        cyc();
        chk("g2r2_round", {4'd0, bus.roundNum}, 8'd2);
        show_to_wait("g2r2");
        tick();
        bus.tick1Hz = 1'b1;
        post(8'd9, 8'd9);
        bus.tick1Hz = 1'b0;
        chk("coinc_valid",   {7'd0, bus.resultValid}, 8'd1);
        chk("coinc_correct", {7'd0, bus.correct}, 8'd1);
        chk("coinc_score",   bus.score, 8'd1);
        cyc();
        cyc();
        chk("g2_done_busy", {7'd0, bus.busy}, 8'd0);

        // Asynchronous reset while waiting for postSig.
        start();
        show_to_wait("g3");
        #2;
        RstN = 1'b0;
        #1;
        chk_zero("async_rst");
        cyc();
        cyc();
        chk("rst_hold_answer", {7'd0, bus.answerSig}, 8'd0);
        chk("rst_hold_clear",  {7'd0, bus.clearCount}, 8'd0);
        RstN = 1'b1;
        cyc();
        start();
        chk("after_rst_clear", {7'd0, bus.clearCount}, 8'd1);
        chk("after_rst_round", {4'd0, bus.roundNum}, 8'd1);

        // Saturation from 254 over two correct rounds.
        force dut.scoreQ = 8'd254;
        #1;
        release dut.scoreQ;
        chk("sat_preload", bus.score, 8'd254);
        show_to_wait("sat1");
        post(8'd3, 8'd3);
        chk("sat1_score", bus.score, 8'd255);
        cyc();
        cyc();
        show_to_wait("sat2");
        post(8'd4, 8'd4);
        chk("sat2_score",   bus.score, 8'd255);
        chk("sat2_correct", {7'd0, bus.correct}, 8'd1);
        cyc();
        cyc();
        chk("sat_done_busy", {7'd0, bus.busy}, 8'd0);

`ifdef ROUND_SEQ_SEG_EN
        force dut.scoreQ = 8'd42;
        #1;
        release dut.scoreQ;
        cyc();
        chk("seg0_42", bus.scoreSeg0, 8'h99);
        chk("seg1_42", bus.scoreSeg1, 8'hA4);
`endif

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Game-round initiator on the answer-period handshake. Runs a configurable number of rounds: enables symbol generation for a fixed display time, pulses `answerSig` to open the answer period, waits for `postSig`, samples the player's count, and scores it against the true symbol count. Sits between the start button, the symbol generator and the answer-period timer, on the 100 MHz domain.

## Interface
- `SHOW_SECONDS`, 10: display-period length in 1 Hz ticks, 1..63.
- `ROUNDS`, 5: rounds per game, 1..15.
- `WAIT_TIMEOUT`, 8: ticks allowed in WAIT before the round is forced wrong, 1..63.
- `Clk100M` in 1: sole clock. All logic is on the rising edge.
- `RstN` in 1: asynchronous, active-low reset.
- `tick1Hz` in 1: one-cycle `Clk100M`-synchronous pulse per second.
- `startBtn` in 1: debounced, one-cycle start request.
- `symbolCount` in 8: true symbol count from the generator.
- `userCount` in 8: player's count.
- `postSig` in 1: one-cycle pulse that ends the answer period.
- `answerSig` out 1: one-cycle pulse that opens the answer period.
- `genEnable` out 1: symbol generator run enable.
- `clearCount` out 1: one-cycle pulse that clears the generator and user counters.
- `busy` out 1: game in progress.
- `roundNum` out 4: current round, 1-based.
- `score` out 8: correct-answer count, saturates at 255.
- `resultValid` out 1: one-cycle pulse per judged round.
- `correct` out 1: result of the last round, held until the next judge.

## Operation
- States: IDLE, SHOW, ASK, WAIT, JUDGE, NEXT, DONE.
- IDLE/DONE + `startBtn`:
  - go to SHOW;
  - `score`←0, `roundNum`←1;
  - pulse `clearCount`.
- SHOW:
  - `genEnable`=1;
  - tick counter counts `tick1Hz`;
  - on the SHOW_SECONDS-th tick go to ASK and clear the tick counter.
- ASK: `answerSig`=1 for exactly one cycle, `genEnable`=0, then go to WAIT.
- WAIT:
  - on `postSig`: sample `userCount` and `symbolCount`, then go to JUDGE;
  - otherwise count ticks; at WAIT_TIMEOUT ticks go to JUDGE with a forced mismatch.
- JUDGE:
  - `correct` = sampled counts equal (0 on timeout);
  - `score` += `correct`, saturating;
  - pulse `resultValid`.
- NEXT:
  - if `roundNum` < ROUNDS: `roundNum`+1, pulse `clearCount`, go to SHOW;
  - otherwise go to DONE.
- `busy` = state not in {IDLE, DONE}.
- DONE holds `score`, `roundNum` and `correct` for display.
- Ignored inputs:
  - `startBtn` outside IDLE/DONE;
  - `postSig` outside WAIT.
- `postSig` and the timeout tick in the same cycle: `postSig` wins, and the sampled counts are judged.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-game returns to IDLE with no `answerSig` or `clearCount` emitted.
- `startBtn` at cycle n → SHOW, `genEnable`=1 and `clearCount`=1 at n+1.
- SHOW_SECONDS-th tick at cycle t → `answerSig`=1 and `genEnable`=0 at t+1; state WAIT at t+2.
- `postSig` at m → `resultValid`, `correct` and the updated `score` all visible at m+1.
- At m+2, NEXT decides (registered) between the next round and DONE.
- At m+3 one of two things is visible:
  - next round: `genEnable`=1, `clearCount`=1, incremented `roundNum`;
  - last round: `busy`=0.
- `userCount` is sampled on the `postSig` cycle. The answer-period timer freezes the user count on that same cycle.
- Every output is registered.

## Configuration
- `ROUND_SEQ_SEG_EN` defined:
  - adds outputs `scoreSeg0` and `scoreSeg1` (8 bits each, active-low 7-segment, DP bit 7);
  - they show `score/10` and `score%10`;
  - both read 8'hFF while IDLE;
  - they are registered and update one cycle after `score`.
- Undefined: those ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `symcounter_pkg` holds:
  - the state enum `round_state_t`;
  - the segment constants: digits 0–9, and blank = 8'hFF (digit 7 = 8'hD8);
  - the `int_to_seg` function.
- Sub-module `seg_digit_enc` (4-bit in, 8-bit registered out) is instantiated twice, only under `ROUND_SEQ_SEG_EN`.

## Test plan
- Normal game, ROUNDS=2, SHOW_SECONDS=3: `startBtn` → `answerSig` one cycle after the 3rd tick. `postSig` with `userCount`=7, `symbolCount`=7 → `correct`=1, `score`=1. Round 2 with 5 vs 6 → `correct`=0, `score`=1, DONE, `busy`=0.
- Timeout, WAIT_TIMEOUT=2: no `postSig` → `resultValid` one cycle after the 2nd WAIT tick, `correct`=0. A `postSig` coincident with that tick and equal counts gives `correct`=1.
- Spurious inputs:
  - `postSig` during SHOW: no state change;
  - `startBtn` during WAIT: `roundNum` unchanged.
- Asynchronous reset deasserted… asserted in WAIT → all outputs 0 at once, state IDLE. The next `startBtn` → `clearCount`=1 and `roundNum`=1.
- Score saturation, `score` forced to 254: two correct rounds → 255, 255.
- With `ROUND_SEQ_SEG_EN`, `score`=42: `scoreSeg0`=8'h99, `scoreSeg1`=8'hA4.
